pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter STACK_DEPTH, default 8; number of return-address entries, power of two, minimum 2.
REQ-002 Parameter TRAP_VECTOR, default 8'hFF; address loaded on a stack fault when STACK_GUARD_EN is defined.
REQ-003 Clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low; asserting it clears all state immediately.
REQ-005 iStall  input  1  holds all state for the cycle (e.g. a multi-cycle execute).
REQ-006 iBranchTaken  input  1  taken BEQ/BLE/JMP from execute.
REQ-007 iCall  input  1  CALL decoded this cycle.
REQ-008 iRet  input  1  RET decoded this cycle.
REQ-009 iTarget  input  8  branch/call destination, taken from instruction bits [23:16].
REQ-010 oAddress  output  8  registered program counter, drives ROM iAddress.
REQ-011 oStackDepth  output  log2(STACK_DEPTH)+1  current number of valid return entries.
REQ-012 oStackError  output  1  sticky fault flag; constant 0 when STACK_GUARD_EN is undefined.

Function
REQ-013 oAddress SHALL be registered; a control input sampled at edge N SHALL be reflected on oAddress after edge N.
REQ-014 Per-cycle priority SHALL be: iStall > iRet > iCall > iBranchTaken > sequential increment.
REQ-015 iStall=1: PC, stack and flags unchanged; all other inputs ignored.
REQ-016 Increment: PC <= PC+1, modulo 256; 8'hFF wraps to 8'h00 without any flag.
REQ-017 Branch: PC <= iTarget; stack untouched.
REQ-018 Call: push PC+1 (mod 256) into stack[depth]; depth <= depth+1; PC <= iTarget.
REQ-019 Ret: PC <= stack[depth-1]; depth <= depth-1.
REQ-020 iCall and iRet both high: only the return SHALL execute; the call SHALL be dropped.
REQ-021 Full stack (depth = STACK_DEPTH) with call: behaviour per REQ-027/REQ-028.
REQ-022 Empty stack (depth = 0) with ret: behaviour per REQ-027/REQ-028.
REQ-023 Nested calls SHALL return in LIFO order.

Reset
REQ-024 Reset low SHALL force oAddress=0, oStackDepth=0, oStackError=0 asynchronously, regardless of Clock.
REQ-025 Stack entry contents need not be cleared; depth=0 makes them invalid.
REQ-026 Reset asserted mid-call or mid-stall SHALL abandon the operation; the first post-reset fetch is address 0.

Configuration
REQ-027 With STACK_GUARD_EN defined:
- Call on a full stack or ret on an empty stack: no push or pop occurs.
- PC <= TRAP_VECTOR.
- oStackError set and held until reset.
REQ-028 With STACK_GUARD_EN undefined:
- Depth pointer wraps modulo STACK_DEPTH.
- Call on full overwrites the oldest entry; depth saturates at STACK_DEPTH.
- Ret on empty returns the stale stack[STACK_DEPTH-1]; depth stays 0.
- oStackError tied to 0.

Structure
REQ-029 STACK_DEPTH default, TRAP_VECTOR default and the STACK_GUARD_EN default setting SHALL live in the shared Definitions include, beside the opcode constants.
REQ-030 The return stack SHALL be a sub-module named return_stack.
- Ports: push, pop, push data, top data, depth, full, empty.
- pc_unit holds the PC register and the priority/fault logic.

Verification
REQ-031 Reset release, no controls, 3 edges -> oAddress 0,1,2,3; oStackDepth=0.
REQ-032 Sequence from PC=0: call to 100 at PC=0, 3 increments, ret -> oAddress 0,100,101,102,103,1; depth 0->1->0.
REQ-033 iBranchTaken with iTarget=19 while iStall=1 for 2 cycles, then stall released -> oAddress holds 2 cycles, then 19.
REQ-034 Free-run from PC=8'hFE -> oAddress FE,FF,00; oStackError stays 0.
REQ-035 9 nested calls with STACK_DEPTH=8:
- STACK_GUARD_EN defined -> 9th call gives oAddress=8'hFF, oStackError=1, depth=8.
- Undefined -> depth=8, oStackError=0, 8 rets unwind to the 2nd..9th return addresses.
REQ-036 iCall=1 and iRet=1 together at depth 1, then Reset pulsed low mid-cycle -> ret executes, depth 0; the reset pulse forces oAddress=0 immediately.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg -- shared definitions for the program-counter unit.
//   Opcode constants, PC width, return-stack defaults and the stack-guard
//   build setting. The guard is enabled by defining the macro STACK_GUARD_EN;
//   without it the return stack wraps and no fault is ever raised.
package pc_unit_pkg;

  localparam int unsigned PC_W = 8;

  // Instruction opcodes (bits [31:24] of an instruction word).
  typedef enum logic [7:0] {
    OP_NOP  = 8'h00,
    OP_LOAD = 8'h01,
    OP_ADD  = 8'h02,
    OP_SUB  = 8'h03,
    OP_BEQ  = 8'h10,
    OP_BLE  = 8'h11,
    OP_JMP  = 8'h12,
    OP_CALL = 8'h20,
    OP_RET  = 8'h21
  } opcode_e;

  localparam int STACK_DEPTH_DEFAULT = 8;
  localparam logic [PC_W-1:0] TRAP_VECTOR_DEFAULT = 8'hFF;

`ifdef STACK_GUARD_EN
  localparam bit STACK_GUARD = 1'b1;
`else
  localparam bit STACK_GUARD = 1'b0;
`endif

  // Sequential successor of a PC, modulo 256 (FF wraps silently to 00).
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + 8'd1;
  endfunction

endpackage

// File: rtl/pc_unit_return_stack.sv
// return_stack -- LIFO of return addresses for pc_unit.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset (clears depth only)
//   i_push, i_pop    : push i_push_data / pop top entry (never both at once)
//   i_push_data      : return address to store
//   o_top_data       : entry at index depth-1 (mod DEPTH)
//   o_depth          : number of valid entries, 0..DEPTH
//   o_full, o_empty  : depth == DEPTH / depth == 0
// Entries are indexed directly by depth modulo DEPTH: a push on a full stack
// lands in entry 0 (the oldest) and a pop on an empty stack reads entry
// DEPTH-1. Depth saturates at DEPTH and floors at 0.
module return_stack
  import pc_unit_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH_DEFAULT
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [PC_W-1:0]         i_push_data,
  output logic [PC_W-1:0]         o_top_data,
  output logic [$clog2(DEPTH):0]  o_depth,
  output logic                    o_full,
  output logic                    o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] FULL_COUNT = DW'(DEPTH);

  logic [PC_W-1:0] r_mem [DEPTH];
  logic [DW-1:0]   r_depth;
  logic [AW-1:0]   w_wr_idx;
  logic [AW-1:0]   w_top_idx;

  assign w_wr_idx   = r_depth[AW-1:0];
  // Adding all-ones is a modulo-DEPTH decrement.
  assign w_top_idx  = w_wr_idx + {AW{1'b1}};
  assign o_top_data = r_mem[w_top_idx];
  assign o_depth    = r_depth;
  assign o_full     = (r_depth == FULL_COUNT);
  assign o_empty    = (r_depth == '0);

  // Contents are not reset; depth 0 marks them invalid.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[w_wr_idx] <= i_push_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_depth <= '0;
    end else if (i_pop) begin
      if (!o_empty) r_depth <= r_depth - DW'(1);
    end else if (i_push) begin
      if (!o_full) r_depth <= r_depth + DW'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit -- program counter with call/return stack.
//   Clock        : sole clock, rising edge
//   Reset        : asynchronous active-low; clears PC, depth and fault flag
//   iStall       : freeze all state this cycle
//   iBranchTaken : load iTarget
//   iCall        : push PC+1, load iTarget
//   iRet         : load top of return stack, pop
//   iTarget      : branch/call destination
//   oAddress     : registered PC (ROM address)
//   oStackDepth  : valid return entries
//   oStackError  : sticky stack fault (only with STACK_GUARD_EN, else 0)
// Priority each cycle: stall > ret > call > branch > increment.
// Build option STACK_GUARD_EN: overflow/underflow suppresses the push/pop,
// jumps to TRAP_VECTOR and latches oStackError until reset.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              STACK_DEPTH = STACK_DEPTH_DEFAULT,
  parameter logic [PC_W-1:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         iStall,
  input  logic                         iBranchTaken,
  input  logic                         iCall,
  input  logic                         iRet,
  input  logic [PC_W-1:0]              iTarget,
  output logic [PC_W-1:0]              oAddress,
  output logic [$clog2(STACK_DEPTH):0] oStackDepth,
  output logic                         oStackError
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_top;
  logic            w_do_ret;
  logic            w_do_call;
  logic            w_do_branch;
  logic            w_full;
  logic            w_empty;
  logic            w_fault;
  logic            w_push;
  logic            w_pop;

  // A simultaneous call is dropped in favour of the return.
  assign w_do_ret    = !iStall && iRet;
  assign w_do_call   = !iStall && !iRet && iCall;
  assign w_do_branch = !iStall && !iRet && !iCall && iBranchTaken;

  // STACK_GUARD is a build constant, so without the guard w_fault is 0
  // and the stack's own wrap/saturate behaviour takes over.
  assign w_fault = STACK_GUARD && ((w_do_ret && w_empty) || (w_do_call && w_full));
  assign w_push  = w_do_call && !w_fault;
  assign w_pop   = w_do_ret && !w_fault;
  assign w_pc_inc = pc_inc(r_pc);

  return_stack #(
    .DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .i_clk       (Clock),
    .i_rst_n     (Reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_pc_inc),
    .o_top_data  (w_top),
    .o_depth     (oStackDepth),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_comb begin
    w_pc_next = w_pc_inc;
    if (iStall)                        w_pc_next = r_pc;
    else if (w_fault)                  w_pc_next = TRAP_VECTOR;
    else if (w_do_ret)                 w_pc_next = w_top;
    else if (w_do_call || w_do_branch) w_pc_next = iTarget;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_pc <= '0;
    else        r_pc <= w_pc_next;
  end

  assign oAddress = r_pc;

`ifdef STACK_GUARD_EN
  logic r_error;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)       r_error <= 1'b0;
    else if (w_fault) r_error <= 1'b1;
  end

  assign oStackError = r_error;
`else
  assign oStackError = 1'b0;
`endif

endmodule
